// File: rtl/div_recon_mul.sv
`timescale 1ns/1ps
// Rebuilds x_rec = q*y + r with a shift-add multiplier and reports x_ref - x_rec.
// Optional error statistics under DIV_RECON_ERROR_STATS_EN.
module div_recon_mul #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     q,
  input  logic [W-1:0]     y,
  input  logic [W-1:0]     r,
  input  logic [2*W-1:0]   x_ref,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   x_rec,
  output logic [2*W:0]     err,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2*W:0]     err_max
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   y_q, y_d;
  logic [2*W-1:0] xref_q, xref_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] xrec_q, xrec_d;
  logic [2*W:0]   err_q, err_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [2*W-1:0] addend;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    y_d     = y_q;
    xref_d  = xref_q;
    acc_d   = acc_q;
    xrec_d  = xrec_q;
    err_d   = err_q;
    idx_d   = idx_q;
    addend  = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d     = q;
          y_d     = y;
          xref_d  = x_ref;
          acc_d   = {{W{1'b0}}, r};
          idx_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (q_q[idx_q]) begin
          addend = {{W{1'b0}}, y_q} << idx_q;
        end
        acc_d = acc_q + addend;
        idx_d = idx_q + IW'(1);
        // Last partial product: publish result on the same edge
        if (idx_q == IW'(W - 1)) begin
          state_d = DONE;
          xrec_d  = acc_d;
          err_d   = {1'b0, xref_q} - {1'b0, acc_d};
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      y_q     <= '0;
      xref_q  <= '0;
      acc_q   <= '0;
      xrec_q  <= '0;
      err_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      y_q     <= y_d;
      xref_q  <= xref_d;
      acc_q   <= acc_d;
      xrec_q  <= xrec_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign x_rec     = xrec_q;
  assign err       = err_q;

`ifdef DIV_RECON_ERROR_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W:0]     max_q, max_d;
  logic [2*W:0]     err_abs;

  always_comb begin
    cnt_d   = cnt_q;
    max_d   = max_q;
    err_abs = err_q[2*W] ? (~err_q + (2*W+1)'(1)) : err_q;
    if (stats_clr) begin
      cnt_d = '0;
      max_d = '0;
    end else if (out_valid && out_ready) begin
      if ((err_q != '0) && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (err_abs > max_q) begin
        max_d = err_abs;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      max_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      max_q <= max_d;
    end
  end

  assign err_cnt = cnt_q;
  assign err_max = max_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign err_cnt = '0;
  assign err_max = '0;
`endif

endmodule

// File: tb/tb_div_recon_mul.sv
`timescale 1ns/1ps
// Bench for div_recon_mul: directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_div_recon_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        stats_clr = 1'b0;
  logic [7:0]  q = '0;
  logic [7:0]  y = '0;
  logic [7:0]  r = '0;
  logic [15:0] x_ref = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] x_rec;
  logic [16:0] err;
  logic [15:0] err_cnt;
  logic [16:0] err_max;

  int vec = 0;
  int miss = 0;
  int m_cnt = 0;
  int m_max = 0;

  div_recon_mul #(.W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .y(y), .r(r), .x_ref(x_ref),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_rec(x_rec), .err(err),
    .stats_clr(stats_clr),
    .err_cnt(err_cnt), .err_max(err_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag);
`ifdef DIV_RECON_ERROR_STATS_EN
    chk({tag, "_cnt"}, 64'(err_cnt), 64'(m_cnt));
    chk({tag, "_max"}, 64'(err_max), 64'(m_max));
`else
    chk({tag, "_cnt0"}, 64'(err_cnt), 64'd0);
    chk({tag, "_max0"}, 64'(err_max), 64'd0);
`endif
  endtask

  function automatic void model(input logic [7:0] qi, yi, ri,
                                input logic [15:0] xi,
                                output logic [15:0] ex,
                                output logic [16:0] ee);
    int prod;
    int e;
    prod = int'(qi) * int'(yi) + int'(ri);
    e = int'(xi) - prod;
    ex = prod[15:0];
    ee = e[16:0];
  endfunction

  task automatic start_op(input logic [7:0] qi, yi, ri,
                          input logic [15:0] xi);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_before_accept", 64'(in_ready), 64'd1);
    q = qi; y = yi; r = ri; x_ref = xi;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    q = 8'($urandom); y = 8'($urandom);
    r = 8'($urandom); x_ref = 16'($urandom);
  endtask

  task automatic wait_result(input logic [7:0] qi, yi, ri,
                             input logic [15:0] xi);
    int n = 0;
    logic [15:0] ex;
    logic [16:0] ee;
    model(qi, yi, ri, xi, ex, ee);
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'd8);
    chk("x_rec", 64'(x_rec), 64'(ex));
    chk("err", 64'(err), 64'(ee));
    chk("busy_in_ready", 64'(in_ready), 64'd0);
  endtask

  task automatic finish_op(input int hold, input logic [7:0] qi, yi, ri,
                           input logic [15:0] xi);
    logic [15:0] ex;
    logic [16:0] ee;
    int a;
    model(qi, yi, ri, xi, ex, ee);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_x_rec", 64'(x_rec), 64'(ex));
      chk("hold_err", 64'(err), 64'(ee));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    a = int'(xi) - (int'(qi) * int'(yi) + int'(ri));
    if (a < 0) a = -a;
    if (a != 0 && m_cnt < 65535) m_cnt++;
    if (a > m_max) m_max = a;
    chk("post_hs_valid", 64'(out_valid), 64'd0);
    chk("post_hs_ready", 64'(in_ready), 64'd1);
    chk("post_hs_x_rec", 64'(x_rec), 64'(ex));
    chk_stats("stats");
  endtask

  task automatic do_op(input logic [7:0] qi, yi, ri,
                       input logic [15:0] xi, input int hold);
    start_op(qi, yi, ri, xi);
    wait_result(qi, yi, ri, xi);
    finish_op(hold, qi, yi, ri, xi);
  endtask

  initial begin
    logic [7:0]  rq, ry, rr;
    logic [15:0] rx;

    rst_n = 1'b0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_x_rec", 64'(x_rec), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_err_max", 64'(err_max), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    m_cnt = 0;
    m_max = 0;
    chk_stats("clr0");

    do_op(8'd42, 8'd5, 8'd3, 16'd213, 0);
    chk("exact_err", 64'(err), 64'd0);
    do_op(8'hFF, 8'hFF, 8'hFE, 16'hFFFF, 1);
    chk("extreme_x_rec", 64'(x_rec), 64'hFEFF);
    chk("extreme_err", 64'(err), 64'd256);
    do_op(8'd2, 8'd5, 8'd3, 16'd10, 2);
    chk("neg_err", 64'(err), 64'h1FFFD);
`ifdef DIV_RECON_ERROR_STATS_EN
    chk("stats_cnt_2", 64'(err_cnt), 64'd2);
    chk("stats_max_256", 64'(err_max), 64'd256);
`endif
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    m_cnt = 0;
    m_max = 0;
    chk_stats("clr1");

    do_op(8'hFF, 8'h00, 8'h10, 16'h0010, 0);
    chk("ydiv0_x_rec", 64'(x_rec), 64'h0010);

    // Backpressure with a new operand waiting
    start_op(8'd42, 8'd5, 8'd3, 16'd213);
    wait_result(8'd42, 8'd5, 8'd3, 16'd213);
    q = 8'd7; y = 8'd9; r = 8'd1; x_ref = 16'd70;
    in_valid = 1'b1;
    finish_op(5, 8'd42, 8'd5, 8'd3, 16'd213);
    tick();
    in_valid = 1'b0;
    wait_result(8'd7, 8'd9, 8'd1, 16'd70);
    finish_op(0, 8'd7, 8'd9, 8'd1, 16'd70);

    // Clear and handshake together: clear wins
    start_op(8'd2, 8'd5, 8'd3, 16'd10);
    wait_result(8'd2, 8'd5, 8'd3, 16'd10);
    stats_clr = 1'b1;
    out_ready = 1'b1;
    tick();
    stats_clr = 1'b0;
    out_ready = 1'b0;
    m_cnt = 0;
    m_max = 0;
    chk("clr_hs_ready", 64'(in_ready), 64'd1);
    chk_stats("clr_wins");

    // Reset during the 4th MUL cycle
    start_op(8'd200, 8'd77, 8'd9, 16'd1);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    m_cnt = 0;
    m_max = 0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_x_rec", 64'(x_rec), 64'd0);
    chk_stats("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    do_op(8'd42, 8'd5, 8'd3, 16'd213, 0);
    chk("postrst_x_rec", 64'(x_rec), 64'd213);

    for (int k = 0; k < 30; k++) begin
      rq = 8'($urandom);
      ry = 8'($urandom);
      rr = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        rx = 16'(int'(rq) * int'(ry) + int'(rr));
      else
        rx = 16'($urandom);
      if ((k % 5) == 0) ry = 8'd0;
      do_op(rq, ry, rr, rx, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
